// File: rtl/thread_pc_unit.sv
// thread_pc_unit: per-thread program-counter file feeding the fetch stage.
// Holds one PC and one saved exception PC per hardware thread, advances the
// fetching thread's PC on a clean fetch, applies exception / exception-return /
// branch redirects, and emits a one-cycle squash pulse per redirected thread.
module thread_pc_unit #(
    parameter int unsigned N_THREADS  = 4,
    parameter int unsigned TW         = $clog2(N_THREADS),
    parameter logic [31:0] RESET_PC   = 32'h0000_1000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TW-1:0]        fetch_thread,
    output logic [31:0]          pc,
    input  logic                 fetch_advance,
    input  logic [N_THREADS-1:0] stalled,
    input  logic                 br_en,
    input  logic [TW-1:0]        br_thread,
    input  logic [31:0]          br_target,
    input  logic                 exc_en,
    input  logic [TW-1:0]        exc_thread,
    input  logic [31:0]          exc_pc,
    input  logic                 iret_en,
    input  logic [TW-1:0]        iret_thread,
    input  logic [TW-1:0]        epc_rd_thread,
    output logic [31:0]          epc_rd,
    output logic [N_THREADS-1:0] squash
);

    logic [31:0]          pc_q   [N_THREADS];
    logic [31:0]          pc_d   [N_THREADS];
    logic [31:0]          epc_q  [N_THREADS];
    logic [31:0]          epc_d  [N_THREADS];
    logic [N_THREADS-1:0] squash_q;
    logic [N_THREADS-1:0] squash_d;

    assign pc     = pc_q[fetch_thread];
    assign epc_rd = epc_q[epc_rd_thread];
    assign squash = squash_q;

    // Next-state per thread: exception > iret > branch > advance > hold.
    always_comb begin
        squash_d = '0;
        for (int unsigned i = 0; i < N_THREADS; i++) begin
            pc_d[i]  = pc_q[i];
            epc_d[i] = epc_q[i];
            if (exc_en && (exc_thread == TW'(i))) begin
                pc_d[i]     = EXC_VECTOR;
                epc_d[i]    = exc_pc;
                squash_d[i] = 1'b1;
            end else if (iret_en && (iret_thread == TW'(i))) begin
                pc_d[i]     = epc_q[i];
                squash_d[i] = 1'b1;
            end else if (br_en && (br_thread == TW'(i))) begin
                pc_d[i]     = {br_target[31:2], 2'b00};
                squash_d[i] = 1'b1;
            end else if (fetch_advance && (fetch_thread == TW'(i)) && !stalled[i]) begin
                pc_d[i] = pc_q[i] + 32'(PC_STEP);
            end
        end
    end

    // PC file, saved-EPC file and squash register; reset wins over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_THREADS; i++) begin
                pc_q[i]  <= RESET_PC;
                epc_q[i] <= '0;
            end
            squash_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_THREADS; i++) begin
                pc_q[i]  <= pc_d[i];
                epc_q[i] <= epc_d[i];
            end
            squash_q <= squash_d;
        end
    end

endmodule

// File: tb/tb_thread_pc_unit.sv
// Directed testbench for thread_pc_unit with a behavioural reference model.
module tb_thread_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  fetch_thread;
    logic [31:0] pc;
    logic        fetch_advance;
    logic [3:0]  stalled;
    logic        br_en;
    logic [1:0]  br_thread;
    logic [31:0] br_target;
    logic        exc_en;
    logic [1:0]  exc_thread;
    logic [31:0] exc_pc;
    logic        iret_en;
    logic [1:0]  iret_thread;
    logic [1:0]  epc_rd_thread;
    logic [31:0] epc_rd;
    logic [3:0]  squash;

    int checks = 0;
    int errors = 0;

    thread_pc_unit #(
        .N_THREADS (4),
        .RESET_PC  (32'h0000_1000),
        .EXC_VECTOR(32'h0000_2000),
        .PC_STEP   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_thread (fetch_thread),
        .pc           (pc),
        .fetch_advance(fetch_advance),
        .stalled      (stalled),
        .br_en        (br_en),
        .br_thread    (br_thread),
        .br_target    (br_target),
        .exc_en       (exc_en),
        .exc_thread   (exc_thread),
        .exc_pc       (exc_pc),
        .iret_en      (iret_en),
        .iret_thread  (iret_thread),
        .epc_rd_thread(epc_rd_thread),
        .epc_rd       (epc_rd),
        .squash       (squash)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state per thread.
    logic [31:0] m_pc  [4];
    logic [31:0] m_epc [4];
    logic [3:0]  m_sq;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 4; t++) begin
                m_pc[t]  <= 32'h0000_1000;
                m_epc[t] <= 32'h0;
            end
            m_sq    <= 4'b0;
            m_valid <= 1'b1;
        end else begin
            logic [3:0] sq;
            sq = 4'b0;
            for (int t = 0; t < 4; t++) begin
                if (exc_en && exc_thread == 2'(t)) begin
                    m_pc[t]  <= 32'h0000_2000;
                    m_epc[t] <= exc_pc;
                    sq[t] = 1'b1;
                end else if (iret_en && iret_thread == 2'(t)) begin
                    m_pc[t] <= m_epc[t];
                    sq[t] = 1'b1;
                end else if (br_en && br_thread == 2'(t)) begin
                    m_pc[t] <= br_target & 32'hFFFF_FFFC;
                    sq[t] = 1'b1;
                end else if (fetch_advance && fetch_thread == 2'(t) && !stalled[t]) begin
                    m_pc[t] <= m_pc[t] + 32'd4;
                end
            end
            m_sq <= sq;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle, away from the active edge, compare outputs with the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc", pc, m_pc[fetch_thread]);
            chk("model_epc", epc_rd, m_epc[epc_rd_thread]);
            chk("model_squash", {28'b0, squash}, {28'b0, m_sq});
        end
    end

    task automatic clear_inputs();
        rst = 1'b0; fetch_advance = 1'b0; stalled = 4'b0;
        br_en = 1'b0; br_thread = 2'd0; br_target = 32'h0;
        exc_en = 1'b0; exc_thread = 2'd0; exc_pc = 32'h0;
        iret_en = 1'b0; iret_thread = 2'd0;
    endtask

    // Advance one clock edge, then clear the one-shot controls.
    task automatic cyc();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic peek_pc(input string name, input int t, input logic [31:0] exp);
        fetch_thread = 2'(t);
        #1;
        chk(name, pc, exp);
    endtask

    task automatic peek_epc(input string name, input int t, input logic [31:0] exp);
        epc_rd_thread = 2'(t);
        #1;
        chk(name, epc_rd, exp);
    endtask

    initial begin
        clear_inputs();
        fetch_thread = 2'd0;
        epc_rd_thread = 2'd0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        cyc();

        // Reset state
        peek_pc("rst_pc0", 0, 32'h1000);
        peek_pc("rst_pc3", 3, 32'h1000);
        peek_epc("rst_epc2", 2, 32'h0);
        chk("rst_squash", {28'b0, squash}, 32'h0);

        // Round-robin fetch with advance
        for (int r = 0; r < 3; r++) begin
            for (int t = 0; t < 4; t++) begin
                fetch_thread = 2'(t);
                fetch_advance = 1'b1;
                #1;
                chk("rr_pc", pc, 32'h1000 + 32'(4 * r));
                cyc();
            end
        end

        // Stalled thread does not advance
        fetch_thread = 2'd2; fetch_advance = 1'b1; stalled = 4'b0100;
        cyc();
        peek_pc("stall_pc2", 2, 32'h100C);
        chk("stall_squash", {28'b0, squash}, 32'h0);

        // Branch overrides same-cycle advance; target low bits dropped
        fetch_thread = 2'd1; fetch_advance = 1'b1;
        br_en = 1'b1; br_thread = 2'd1; br_target = 32'h0000_3007;
        cyc();
        chk("br_squash", {28'b0, squash}, 32'h2);
        peek_pc("br_pc1", 1, 32'h3004);
        cyc();
        chk("br_squash_clear", {28'b0, squash}, 32'h0);

        // Exception beats branch on the same thread; then return
        exc_en = 1'b1; exc_thread = 2'd3; exc_pc = 32'h1010;
        br_en = 1'b1; br_thread = 2'd3; br_target = 32'h5000;
        cyc();
        chk("exc_squash", {28'b0, squash}, 32'h8);
        peek_pc("exc_pc3", 3, 32'h2000);
        peek_epc("exc_epc3", 3, 32'h1010);
        peek_pc("exc_pc0_untouched", 0, 32'h100C);
        cyc();
        iret_en = 1'b1; iret_thread = 2'd3;
        cyc();
        chk("iret_squash", {28'b0, squash}, 32'h8);
        peek_pc("iret_pc3", 3, 32'h1010);
        peek_epc("iret_epc3_kept", 3, 32'h1010);

        // Independent redirects on different threads
        exc_en = 1'b1; exc_thread = 2'd0; exc_pc = 32'h1234;
        br_en = 1'b1; br_thread = 2'd2; br_target = 32'h4000;
        cyc();
        chk("multi_squash", {28'b0, squash}, 32'h5);
        peek_pc("multi_pc0", 0, 32'h2000);
        peek_pc("multi_pc2", 2, 32'h4000);
        peek_epc("multi_epc0", 0, 32'h1234);

        // Back-to-back redirects give consecutive pulses
        br_en = 1'b1; br_thread = 2'd1; br_target = 32'h6000;
        cyc();
        chk("b2b_squash1", {28'b0, squash}, 32'h2);
        br_en = 1'b1; br_thread = 2'd1; br_target = 32'h7000;
        cyc();
        chk("b2b_squash2", {28'b0, squash}, 32'h2);
        peek_pc("b2b_pc1", 1, 32'h7000);

        // Wrap-around at the top of the address space
        br_en = 1'b1; br_thread = 2'd0; br_target = 32'hFFFF_FFFC;
        cyc();
        fetch_thread = 2'd0; fetch_advance = 1'b1;
        cyc();
        peek_pc("wrap_pc0", 0, 32'h0);

        // Mid-run reset overrides a concurrent branch
        rst = 1'b1; br_en = 1'b1; br_thread = 2'd2; br_target = 32'h8000;
        cyc();
        chk("mrst_squash", {28'b0, squash}, 32'h0);
        peek_pc("mrst_pc1", 1, 32'h1000);
        peek_pc("mrst_pc2", 2, 32'h1000);
        peek_epc("mrst_epc0", 0, 32'h0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
